// File: rtl/fm_synth_poly_if.sv
// Sample handshake between the FM synthesizer and the downstream sample FIFO.
// The producer holds sample/sample_valid until the consumer raises sample_ready.
interface fm_synth_poly_if;
    logic [13:0] sample;
    logic        sample_valid;
    logic        sample_ready;

    modport master (output sample, output sample_valid, input sample_ready);
    modport slave  (input sample, input sample_valid, output sample_ready);
endinterface

// File: rtl/fm_synth_poly.sv
// Time-multiplexed polyphonic FM synthesizer: per-voice carrier/modulator phases share one sine LUT.
// Optional per-voice attack/release envelope is enabled by defining SYNTH_ENVELOPE_EN.
module fm_synth_poly #(
    parameter int N_VOICES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [24*N_VOICES-1:0] carrier_fcws,
    input  logic [24*N_VOICES-1:0] mod_fcws,
    input  logic [4:0]             mod_shift,
    input  logic [N_VOICES-1:0]    note_en,
    input  logic [7:0]             attack_step,
    input  logic [7:0]             release_step,
    fm_synth_poly_if.master        smp
);
    localparam int L  = $clog2(N_VOICES);
    localparam int VW = (L == 0) ? 1 : L;
    localparam int AW = 14 + L;

    typedef enum logic [2:0] {S_MOD, S_CAR, S_ACC, S_OUT, S_WAIT} state_t;

    // round(8191*sin(pi/2*k/256)) in Q30 fixed point; only ever called with constant k.
    function automatic logic [13:0] quarter_sine(input int k);
        longint x;
        longint x2;
        longint t;
        longint s;
        longint d;
        x  = (longint'(k) * 64'sd1686629713) / 64'sd256;
        x2 = (x * x) >>> 30;
        t  = 64'sd1073741824;
        for (int j = 0; j < 6; j++) begin
            case (j)
                0:       d = 64'sd156;
                1:       d = 64'sd110;
                2:       d = 64'sd72;
                3:       d = 64'sd42;
                4:       d = 64'sd20;
                default: d = 64'sd6;
            endcase
            t = 64'sd1073741824 - ((x2 * t) >>> 30) / d;
        end
        s = (x * t) >>> 30;
        return 14'((s * 64'sd8191 + 64'sd536870912) >>> 30);
    endfunction

    logic [13:0] quarter_rom [0:256];

    for (genvar g = 0; g <= 256; g++) begin : g_rom
        localparam logic [13:0] QV = quarter_sine(g);
        assign quarter_rom[g] = QV;
    end

    state_t             state_r;
    logic [VW-1:0]      v_r;
    logic [23:0]        mod_phase_r [N_VOICES];
    logic [23:0]        car_phase_r [N_VOICES];
    logic [8:0]         gain_r      [N_VOICES];
    logic signed [AW-1:0] acc_r;
    logic [13:0]        sample_r;
    logic               valid_r;
    logic signed [13:0] lut_data_r;

    logic [9:0]         lut_addr_s;
    logic [8:0]         rom_idx_s;
    logic [13:0]        rom_mag_s;
    logic [23:0]        mod_next_s;
    logic [23:0]        mod_term_s;
    logic [23:0]        car_next_s;
    logic signed [23:0] prod_s;
    logic signed [AW-1:0] voice_s;
    logic [8:0]         gain_next_s;
    logic               last_voice_s;

    // Per-voice next-state arithmetic for the voice currently in the datapath.
    always_comb begin
        mod_next_s   = mod_phase_r[v_r] + mod_fcws[24*v_r +: 24];
        mod_term_s   = {{10{lut_data_r[13]}}, lut_data_r} << mod_shift;
        car_next_s   = car_phase_r[v_r] + carrier_fcws[24*v_r +: 24] + mod_term_s;
        prod_s       = 24'(lut_data_r) * 24'($signed({1'b0, gain_r[v_r]}));
        voice_s      = AW'(prod_s >>> 8);
        last_voice_s = (v_r == VW'(N_VOICES - 1));
        case (state_r)
            S_MOD:   lut_addr_s = mod_next_s[23:14];
            S_CAR:   lut_addr_s = car_next_s[23:14];
            default: lut_addr_s = 10'd0;
        endcase
    end

`ifdef SYNTH_ENVELOPE_EN
    logic [9:0] gain_up_s;
    logic [9:0] gain_dn_s;

    // Linear attack saturating at unity gain, linear release floored at silence.
    always_comb begin
        gain_up_s = {1'b0, gain_r[v_r]} + {2'b00, attack_step};
        gain_dn_s = {1'b0, gain_r[v_r]} - {2'b00, release_step};
        if (note_en[v_r]) begin
            gain_next_s = (gain_up_s > 10'd256) ? 9'd256 : gain_up_s[8:0];
        end else begin
            gain_next_s = (gain_r[v_r] < {1'b0, release_step}) ? 9'd0 : gain_dn_s[8:0];
        end
    end
`else
    logic unused_steps_s;
    assign unused_steps_s = ^{attack_step, release_step};

    // Plain gate: full gain while the note is held, silence otherwise.
    always_comb begin
        if (note_en[v_r]) begin
            gain_next_s = 9'd256;
        end else begin
            gain_next_s = 9'd0;
        end
    end
`endif

    // Quarter-wave folding of the 10-bit LUT address.
    always_comb begin
        if (lut_addr_s[8]) begin
            rom_idx_s = 9'd256 - {1'b0, lut_addr_s[7:0]};
        end else begin
            rom_idx_s = {1'b0, lut_addr_s[7:0]};
        end
        rom_mag_s = quarter_rom[rom_idx_s];
    end

    // Synchronous sine read; the lower half-cycle is the negated upper half.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lut_data_r <= 14'sd0;
        end else if (lut_addr_s[9]) begin
            lut_data_r <= -$signed(rom_mag_s);
        end else begin
            lut_data_r <= $signed(rom_mag_s);
        end
    end

    // Voice sequencer: modulator, carrier and accumulate pass per voice, then hand off the mix.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= S_MOD;
            v_r      <= '0;
            acc_r    <= '0;
            sample_r <= 14'd0;
            valid_r  <= 1'b0;
            for (int i = 0; i < N_VOICES; i++) begin
                mod_phase_r[i] <= 24'd0;
                car_phase_r[i] <= 24'd0;
                gain_r[i]      <= 9'd0;
            end
        end else begin
            case (state_r)
                S_MOD: begin
                    mod_phase_r[v_r] <= mod_next_s;
                    gain_r[v_r]      <= gain_next_s;
                    state_r          <= S_CAR;
                end
                S_CAR: begin
                    car_phase_r[v_r] <= car_next_s;
                    state_r          <= S_ACC;
                end
                S_ACC: begin
                    acc_r <= (v_r == '0) ? voice_s : acc_r + voice_s;
                    if (last_voice_s) begin
                        state_r <= S_OUT;
                    end else begin
                        v_r     <= v_r + 1'b1;
                        state_r <= S_MOD;
                    end
                end
                S_OUT: begin
                    sample_r <= 14'(acc_r >>> L);
                    valid_r  <= 1'b1;
                    state_r  <= S_WAIT;
                end
                S_WAIT: begin
                    if (valid_r && smp.sample_ready) begin
                        valid_r <= 1'b0;
                        v_r     <= '0;
                        state_r <= S_MOD;
                    end else begin
                        state_r <= S_WAIT;
                    end
                end
                default: state_r <= S_MOD;
            endcase
        end
    end

    assign smp.sample       = sample_r;
    assign smp.sample_valid = valid_r;
endmodule

// File: tb/tb_fm_synth_poly.sv
// Directed bench for fm_synth_poly: a 1-voice and a 2-voice instance, default or SYNTH_ENVELOPE_EN build.
module tb_fm_synth_poly;
    logic        clk;
    logic        rst1_n;
    logic        rst2_n;
    logic [23:0] car1;
    logic [23:0] mod1;
    logic [47:0] car2;
    logic [47:0] mod2;
    logic [4:0]  sh1;
    logic [4:0]  sh2;
    logic [0:0]  en1;
    logic [1:0]  en2;
    logic [7:0]  att;
    logic [7:0]  rel;

    int n_cmp = 0;
    int n_err = 0;
    int n;

`ifdef SYNTH_ENVELOPE_EN
    int exp_a [8] = '{2047, 0, -6144, 0, 8191, 0, -4096, 0};
    int exp_9  = 2047;
    int exp_n2 [3] = '{1023, 2047, -1024};
`else
    int exp_a [8] = '{8191, 0, -8191, 0, 8191, 0, 0, 0};
    int exp_9  = 8191;
    int exp_n2 [3] = '{4095, 8191, -4096};
`endif

    fm_synth_poly_if if1 ();
    fm_synth_poly_if if2 ();

    fm_synth_poly #(.N_VOICES(1)) dut1 (
        .clk(clk), .rst_n(rst1_n), .carrier_fcws(car1), .mod_fcws(mod1),
        .mod_shift(sh1), .note_en(en1), .attack_step(att), .release_step(rel),
        .smp(if1)
    );

    fm_synth_poly #(.N_VOICES(2)) dut2 (
        .clk(clk), .rst_n(rst2_n), .carrier_fcws(car2), .mod_fcws(mod2),
        .mod_shift(sh2), .note_en(en2), .attack_step(att), .release_step(rel),
        .smp(if2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int vld(input int which);
        return (which == 1) ? int'(if1.sample_valid) : int'(if2.sample_valid);
    endfunction

    function automatic int smp(input int which);
        return (which == 1) ? int'($signed(if1.sample)) : int'($signed(if2.sample));
    endfunction

    task automatic wait_valid(input int which, output int cyc);
        cyc = 0;
        while (cyc < 100) begin
            tick();
            cyc++;
            if (vld(which) == 1) break;
        end
        chk("valid_seen", vld(which), 1);
    endtask

    initial begin
        rst1_n = 1'b0; rst2_n = 1'b0;
        car1 = 24'h400000; mod1 = 24'h000000; sh1 = 5'd0; en1 = 1'b1;
        car2 = {24'h400000, 24'h400000}; mod2 = 48'h0; sh2 = 5'd0; en2 = 2'b01;
        att = 8'd64; rel = 8'd0;
        if1.sample_ready = 1'b1;
        if2.sample_ready = 1'b1;
        repeat (3) tick();
        chk("rst_sample", smp(1), 0);
        chk("rst_valid", vld(1), 0);

        // Single voice stream with a 20-cycle stall on the third sample.
        rst1_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wait_valid(1, n);
            chk((i == 0) ? "first_latency" : "period", n, (i == 0) ? 4 : 5);
            chk("stream_sample", smp(1), exp_a[i]);
            if (i == 2) begin
                if1.sample_ready = 1'b0;
                for (int k = 0; k < 20; k++) begin
                    tick();
                    chk("bp_valid", vld(1), 1);
                    chk("bp_hold", smp(1), exp_a[2]);
                end
                if1.sample_ready = 1'b1;
            end
            if (i == 5) begin
                en1 = 1'b0;
                rel = 8'd128;
            end
        end

        // Re-gate, then reset while voice 0 is in S_CAR.
        en1 = 1'b1;
        wait_valid(1, n);
        chk("period9", n, 5);
        chk("sample9", smp(1), exp_9);
        tick();
        chk("hs_valid_low", vld(1), 0);
        tick();
        rst1_n = 1'b0;
        #1;
        chk("midrst_sample", smp(1), 0);
        chk("midrst_valid", vld(1), 0);

        // Modulation shifted past 24 bits must vanish.
        mod1 = 24'h100000;
        sh1 = 5'd31;
        tick();
        rst1_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_valid(1, n);
            chk((i == 0) ? "rerun_latency" : "rerun_period", n, (i == 0) ? 4 : 5);
            chk("rerun_sample", smp(1), exp_a[i]);
        end

        // Two voices: one gated, then both, then modulated voice 0.
        rst2_n = 1'b1;
        wait_valid(2, n);
        chk("n2_latency", n, 7);
        chk("n2_one_voice", smp(2), exp_n2[0]);
        wait_valid(2, n);
        chk("n2_period", n, 8);
        chk("n2_second", smp(2), 0);
        rst2_n = 1'b0;
        tick();
        en2 = 2'b11;
        rst2_n = 1'b1;
        wait_valid(2, n);
        chk("n2_two_voice", smp(2), exp_n2[1]);
        rst2_n = 1'b0;
        tick();
        en2 = 2'b01;
        mod2 = {24'h000000, 24'h400000};
        sh2 = 5'd10;
        rst2_n = 1'b1;
        wait_valid(2, n);
        chk("n2_mod_latency", n, 7);
        chk("n2_modulated", smp(2), exp_n2[2]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/fm_synth_poly.md
# fm_synth_poly

Polyphonic FM synthesizer with a time-multiplexed datapath: N_VOICES voices, each with its own carrier and modulator phase accumulators, share one sine LUT and one multiplier. The block sums the voices into one 14-bit signed sample per handshake. It sits between the note/control register block and the audio PWM/DAC sample FIFO. It replaces the single-modulator synth with a per-voice modulator and an optional per-voice amplitude envelope.

## Interface
- N_VOICES, 4, voice count; power of two, 1..16; L = log2(N_VOICES)
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- carrier_fcws  in  24*N_VOICES  per-voice carrier FCW; voice v at [24v+23:24v]
- mod_fcws  in  24*N_VOICES  per-voice modulator FCW; same packing
- mod_shift  in  5  modulation depth, left-shift applied to the modulator sine
- note_en  in  N_VOICES  per-voice gate
- attack_step  in  8  envelope gain increment per sample (envelope build only)
- release_step  in  8  envelope gain decrement per sample (envelope build only)
- sample  out  14  signed mixed sample
- sample_valid  out  1  sample is held and ready to be taken
- sample_ready  in  1  consumer accepts the sample

## Operation
- Sine LUT: 1024 entries, signed 14-bit, lut[i] = round(8191*sin(2*pi*i/1024)). Synchronous read: data is valid one cycle after the address is presented. The LUT is indexed by phase[23:14].
- FSM states: S_MOD, S_CAR, S_ACC (one pass per voice v = 0..N_VOICES-1), then S_OUT, then S_WAIT.
- S_MOD:
  - mod_phase[v] += mod_fcws[v], wrapping modulo 2^24.
  - LUT address = new mod_phase[23:14].
  - Update gain[v] (see Configuration).
- S_CAR:
  - m = LUT data.
  - car_phase[v] += carrier_fcws[v] + (sext24(m) << mod_shift). Every term is truncated to 24 bits and the sum wraps.
  - LUT address = new car_phase[23:14].
- S_ACC:
  - c = LUT data.
  - voice_out = (c * gain[v]) >>> 8 (signed 14x9 product).
  - acc += voice_out. acc is (14+L) bits signed, cleared at the start of voice 0.
  - If v < N_VOICES-1: v++ and go to S_MOD. Otherwise go to S_OUT.
- S_OUT: sample <= (acc >>> L)[13:0], sample_valid <= 1, go to S_WAIT.
- S_WAIT: hold sample and sample_valid until sample_valid && sample_ready, then clear sample_valid, set v = 0, and go to S_MOD.
- Phases and gains advance exactly once per delivered sample. They never advance while a sample is waiting.
- Inputs are sampled during compute only. Changes while in S_WAIT take effect in the next sample.
- Phases keep running when note_en is 0. Only the gain is gated.

## Timing
- Reset values: sample = 0, sample_valid = 0, all phases = 0, all gains = 0, acc = 0, v = 0, state = S_MOD.
- Latency: sample_valid rises 3*N_VOICES + 1 cycles after rst_n deasserts, or after the handshake edge.
- Throughput: one sample per 3*N_VOICES + 2 cycles when sample_ready is held high.
- sample is stable for as long as sample_valid = 1. sample_ready while sample_valid = 0 is ignored.
- The handshake completes on a rising edge with sample_valid && sample_ready. sample_valid is 0 in the following cycle.
- rst_n asserted mid-computation or mid-wait clears all state immediately. The partial sample is discarded.

## Configuration
- SYNTH_ENVELOPE_EN defined:
  - gain[v] is 9-bit, range 0..256.
  - In S_MOD: if note_en[v], gain = min(gain + attack_step, 256). Otherwise gain = max(gain - release_step, 0).
- SYNTH_ENVELOPE_EN undefined:
  - gain[v] = note_en[v] ? 256 : 0, applied at S_MOD.
  - attack_step and release_step are unused.

## Test plan
- Envelope off, N_VOICES=1, carrier_fcw=0x400000, mod_fcw=0, note_en=1, ready held high -> samples 8191, 0, -8191, 0, 8191; valid period 5 cycles; first valid 4 cycles after reset release.
- Envelope off, N_VOICES=2, both carrier_fcw=0x400000, note_en=2'b01 -> first sample 4095; with note_en=2'b11 -> 8191.
- Backpressure: ready low for 20 cycles after valid -> sample and valid held constant; after the handshake, the next sample matches the unstalled sequence with no skipped phase step.
- Envelope on, N_VOICES=1, carrier_fcw=0x400000, attack_step=64, note_en=1 -> gains 64, 128, 192, 256, 256 give samples 2047, 0, -6144, 0, 8191. Then note_en=0 with release_step=128 -> gains 128, 0 give the next two samples -4096, 0.
- mod_shift wrap: mod_fcw=0x100000, mod_shift=31 -> modulation term is 0 (truncated); output identical to the mod_fcw=0 run.
- Reset mid-compute: assert rst_n=0 during S_CAR of voice 0 -> sample=0 and valid=0 immediately; after release the sequence restarts from the first scenario's values.
